// File: rtl/nibble_add_pkg.sv
// nibble_add_pkg: shared nibble width and sequencer state encoding
// Rev 1.0
`default_nettype none

package nibble_add_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

endpackage

`default_nettype wire

// File: rtl/ripple_add_4bit_structural.sv
// ripple_add_4bit_structural: gate-level 4-bit ripple-carry adder
// Rev 1.0
`default_nettype none

module ripple_add_4bit_structural
  import nibble_add_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                carry_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                carry_out
);

  logic [NIBBLE_W:0] w_c;

  assign w_c[0] = carry_in;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ w_c[i];
    assign w_c[i+1] = (a[i] & b[i]) | (w_c[i] & (a[i] ^ b[i]));
  end

  assign carry_out = w_c[NIBBLE_W];

endmodule

`default_nettype wire

// File: rtl/nibble_serial_add_ctrl.sv
// nibble_serial_add_ctrl: adds WIDTH-bit operands one nibble per clock through one shared 4-bit adder.
// Optional NSA_ADD_SUB_EN adds a 'sub' port (A - B via inverted B and carry seed 1). Rev 1.0
`default_nettype none

module nibble_serial_add_ctrl
  import nibble_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
`ifdef NSA_ADD_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             busy
);

  localparam int NIBBLES = WIDTH / NIBBLE_W;
  localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  state_t             r_state;
  state_t             w_next_state;
  logic [IDX_W-1:0]   r_idx;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_sum;
  logic               r_carry;
  logic               r_co;
  logic [NIBBLE_W-1:0] w_a_nib;
  logic [NIBBLE_W-1:0] w_b_nib;
  logic [NIBBLE_W-1:0] w_b_add;
  logic [NIBBLE_W-1:0] w_sum_nib;
  logic               w_co_nib;
  logic               w_seed;

`ifdef NSA_ADD_SUB_EN
  logic r_sub;

  always_ff @(posedge clk) begin
    if (rst)
      r_sub <= 1'b0;
    else if (r_state == IDLE && in_valid)
      r_sub <= sub;
  end

  // Subtraction is A + ~B + 1, so the seed overrides carry_in.
  assign w_b_add = r_sub ? ~w_b_nib : w_b_nib;
  assign w_seed  = sub ? 1'b1 : carry_in;
`else
  assign w_b_add = w_b_nib;
  assign w_seed  = carry_in;
`endif

  always_ff @(posedge clk) begin
    if (rst)
      r_state <= IDLE;
    else
      r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (in_valid) w_next_state = RUN;
      RUN:     if (r_idx == LAST_IDX) w_next_state = DONE;
      DONE:    if (out_ready) w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Nibble mux feeding the shared adder.
  always_comb begin
    w_a_nib = '0;
    w_b_nib = '0;
    for (int n = 0; n < NIBBLES; n++) begin
      if (r_idx == IDX_W'(n)) begin
        w_a_nib = r_a[n*NIBBLE_W +: NIBBLE_W];
        w_b_nib = r_b[n*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  ripple_add_4bit_structural u_adder (
    .a         (w_a_nib),
    .b         (w_b_add),
    .carry_in  (r_carry),
    .sum       (w_sum_nib),
    .carry_out (w_co_nib)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_carry <= 1'b0;
      r_co    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_idx   <= '0;
            r_carry <= w_seed;
          end
        end
        RUN: begin
          for (int n = 0; n < NIBBLES; n++) begin
            if (r_idx == IDX_W'(n))
              r_sum[n*NIBBLE_W +: NIBBLE_W] <= w_sum_nib;
          end
          r_carry <= w_co_nib;
          // idx holds at the last nibble instead of wrapping.
          if (r_idx == LAST_IDX)
            r_co <= w_co_nib;
          else
            r_idx <= r_idx + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == IDLE);
  assign out_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign sum       = r_sum;
  assign carry_out = r_co;

endmodule

`default_nettype wire

// File: tb/tb_nibble_serial_add_ctrl.sv
// tb_nibble_serial_add_ctrl: directed self-checking bench for nibble_serial_add_ctrl (WIDTH=16)
// Rev 1.0
`default_nettype none

module tb_nibble_serial_add_ctrl;

  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             carry_in;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;
  logic             busy;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nibble_serial_add_ctrl #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .carry_in  (carry_in),
`ifdef NSA_ADD_SUB_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out),
    .busy      (busy)
  );

  // Presents operands for one cycle; returns #1 after the accept edge.
  task automatic start_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb,
                          input logic tci, input logic tsub);
    a = ta; b = tb; carry_in = tci; sub = tsub; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Edges counted with the accept edge as edge 1; gives up after 20.
  task automatic wait_done(output int edges);
    edges = 1;
    while (!out_valid && edges < 20) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    n_cmp++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if (sum !== 16'h0000) begin n_fail++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    n_cmp++; if (carry_out !== 1'b0) begin n_fail++; $display("FAIL reset_carry_out got=%b exp=0", carry_out); end
  endtask

  task automatic test_zero_latency();
    int edges;
    start_op(16'h0000, 16'h0000, 1'b0, 1'b0);
    n_cmp++; if (busy !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL run_busy busy=%b in_ready=%b exp busy=1 in_ready=0", busy, in_ready); end
    wait_done(edges);
    n_cmp++; if (edges !== 5) begin n_fail++; $display("FAIL zero_latency got=%0d exp=5", edges); end
    n_cmp++; if (sum !== 16'h0000 || carry_out !== 1'b0) begin n_fail++; $display("FAIL zero_sum got=%h/%b exp=0000/0", sum, carry_out); end
    finish_op();
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL zero_release in_ready=%b out_valid=%b busy=%b exp 1/0/0", in_ready, out_valid, busy); end
  endtask

  task automatic test_carry_ripple();
    int edges;
    start_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    wait_done(edges);
    n_cmp++; if (edges !== 5) begin n_fail++; $display("FAIL ripple_latency got=%0d exp=5", edges); end
    n_cmp++; if (sum !== 16'h0000 || carry_out !== 1'b1) begin n_fail++; $display("FAIL ripple_sum got=%h/%b exp=0000/1", sum, carry_out); end
    finish_op();
  endtask

  task automatic test_back_to_back();
    int edges;
    start_op(16'h1234, 16'h4321, 1'b1, 1'b0);
    wait_done(edges);
    n_cmp++; if (sum !== 16'h5556 || carry_out !== 1'b0) begin n_fail++; $display("FAIL b2b_first got=%h/%b exp=5556/0", sum, carry_out); end
    finish_op();
    n_cmp++; if (sum !== 16'h5556) begin n_fail++; $display("FAIL b2b_sum_held got=%h exp=5556", sum); end
    start_op(16'h0003, 16'h0006, 1'b0, 1'b0);
    wait_done(edges);
    n_cmp++; if (edges !== 5) begin n_fail++; $display("FAIL b2b_latency got=%0d exp=5", edges); end
    n_cmp++; if (sum !== 16'h0009 || carry_out !== 1'b0) begin n_fail++; $display("FAIL b2b_second got=%h/%b exp=0009/0", sum, carry_out); end
    finish_op();
  endtask

  task automatic test_backpressure();
    int edges;
    start_op(16'h00AA, 16'h0011, 1'b0, 1'b0);
    wait_done(edges);
    for (int i = 0; i < 3; i++) begin
      a = 16'hDEAD; b = 16'hBEEF; in_valid = (i == 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      n_cmp++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL hold_flags[%0d] out_valid=%b in_ready=%b exp 1/0", i, out_valid, in_ready); end
      n_cmp++; if (sum !== 16'h00BB || carry_out !== 1'b0) begin n_fail++; $display("FAIL hold_sum[%0d] got=%h/%b exp=00BB/0", i, sum, carry_out); end
    end
    finish_op();
    @(posedge clk); #1;
    n_cmp++; if (in_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL hold_no_capture in_ready=%b busy=%b exp 1/0", in_ready, busy); end
  endtask

  task automatic test_reset_mid_run();
    start_op(16'h1111, 16'h1111, 1'b0, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    n_cmp++; if (sum !== 16'h0022) begin n_fail++; $display("FAIL midrun_partial got=%h exp=0022", sum); end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_cmp++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL midrun_flags in_ready=%b out_valid=%b busy=%b exp 1/0/0", in_ready, out_valid, busy); end
    n_cmp++; if (sum !== 16'h0000 || carry_out !== 1'b0) begin n_fail++; $display("FAIL midrun_sum got=%h/%b exp=0000/0", sum, carry_out); end
  endtask

`ifdef NSA_ADD_SUB_EN
  task automatic test_sub();
    int edges;
    start_op(16'h0005, 16'h0007, 1'b0, 1'b1);
    wait_done(edges);
    n_cmp++; if (sum !== 16'hFFFE || carry_out !== 1'b0) begin n_fail++; $display("FAIL sub_borrow got=%h/%b exp=FFFE/0", sum, carry_out); end
    finish_op();
    start_op(16'h0007, 16'h0005, 1'b0, 1'b1);
    wait_done(edges);
    n_cmp++; if (sum !== 16'h0002 || carry_out !== 1'b1) begin n_fail++; $display("FAIL sub_noborrow got=%h/%b exp=0002/1", sum, carry_out); end
    finish_op();
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
    @(posedge clk); #1;
    test_reset();
    test_zero_latency();
    test_carry_ripple();
    test_back_to_back();
    test_backpressure();
    test_reset_mid_run();
`ifdef NSA_ADD_SUB_EN
    test_sub();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
